// File: rtl/mux_pkg.sv
// Shared constants and select type for the 32:1 registered lane selector.
package mux_pkg;

  localparam int unsigned NUM_LANES  = 32;
  localparam int unsigned SEL_W      = 5;
  localparam int unsigned HALF_LANES = NUM_LANES / 2;
  localparam int unsigned HALF_SEL_W = SEL_W - 1;

  typedef logic [SEL_W-1:0]      sel_t;
  typedef logic [HALF_SEL_W-1:0] half_sel_t;

endpackage

// File: rtl/mux16_sel.sv
// Combinational 16:1 lane selector; lane k sits at in_i[k*WIDTH +: WIDTH].
module mux16_sel
  import mux_pkg::*;
#(
  parameter int unsigned WIDTH = 1
) (
  input  logic [HALF_LANES*WIDTH-1:0] in_i,
  input  half_sel_t                   sel_i,
  output logic [WIDTH-1:0]            out_o
);

  logic [HALF_LANES-1:0][WIDTH-1:0] lanes;

  assign lanes = in_i;
  assign out_o = lanes[sel_i];

endmodule

// File: rtl/mux2_sel.sv
// Combinational 2:1 selector used as the final half-select stage.
module mux2_sel #(
  parameter int unsigned WIDTH = 1
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             sel_i,
  output logic [WIDTH-1:0] out_o
);

  assign out_o = sel_i ? b_i : a_i;

endmodule

// File: rtl/mux32_sel_reg.sv
// Registered 32:1 lane selector built as two 16:1 halves plus a 2:1 stage.
// Define MUX32_SEL_PARITY_EN to add out_par, the XOR-reduction of out.
module mux32_sel_reg
  import mux_pkg::*;
#(
  parameter int unsigned WIDTH = 1
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       en,
  input  logic [NUM_LANES*WIDTH-1:0] in,
  input  logic [SEL_W-1:0]           sel,
  output logic [WIDTH-1:0]           out,
  output logic [WIDTH-1:0]           out_comb
`ifdef MUX32_SEL_PARITY_EN
  ,
  output logic                       out_par
`endif
);

  sel_t             sel_s;
  logic [WIDTH-1:0] lo_sel;
  logic [WIDTH-1:0] hi_sel;
  logic [WIDTH-1:0] out_d;
  logic [WIDTH-1:0] out_q;

  assign sel_s = sel;

  mux16_sel #(.WIDTH(WIDTH)) u_lo (
    .in_i  (in[HALF_LANES*WIDTH-1:0]),
    .sel_i (sel_s[HALF_SEL_W-1:0]),
    .out_o (lo_sel)
  );

  mux16_sel #(.WIDTH(WIDTH)) u_hi (
    .in_i  (in[NUM_LANES*WIDTH-1:HALF_LANES*WIDTH]),
    .sel_i (sel_s[HALF_SEL_W-1:0]),
    .out_o (hi_sel)
  );

  mux2_sel #(.WIDTH(WIDTH)) u_half (
    .a_i   (lo_sel),
    .b_i   (hi_sel),
    .sel_i (sel_s[SEL_W-1]),
    .out_o (out_d)
  );

  assign out_comb = out_d;

  // Reset wins over enable so a held-off pipeline still clears.
  always_ff @(posedge clk) begin
    if (!reset_n)  out_q <= '0;
    else if (en)   out_q <= out_d;
  end

  assign out = out_q;

`ifdef MUX32_SEL_PARITY_EN
  logic par_d;
  logic par_q;

  assign par_d = ^out_d;

  always_ff @(posedge clk) begin
    if (!reset_n)  par_q <= 1'b0;
    else if (en)   par_q <= par_d;
  end

  assign out_par = par_q;
`endif

endmodule

// File: tb/tb_mux32_sel_reg.sv
// Directed bench: WIDTH=1 and WIDTH=8 instances share clock, reset and enable.
module tb_mux32_sel_reg;

  logic         clk;
  logic         reset_n;
  logic         en;
  logic [31:0]  in1;
  logic [4:0]   sel1;
  logic [0:0]   out1;
  logic [0:0]   oc1;
  logic [255:0] in8;
  logic [4:0]   sel8;
  logic [7:0]   out8;
  logic [7:0]   oc8;
`ifdef MUX32_SEL_PARITY_EN
  logic         par8;
`endif

  int n_checks;
  int n_fail;

  mux32_sel_reg #(.WIDTH(1)) u_w1 (
    .clk      (clk),
    .reset_n  (reset_n),
    .en       (en),
    .in       (in1),
    .sel      (sel1),
    .out      (out1),
    .out_comb (oc1)
  );

  mux32_sel_reg #(.WIDTH(8)) u_w8 (
    .clk      (clk),
    .reset_n  (reset_n),
    .en       (en),
    .in       (in8),
    .sel      (sel8),
    .out      (out8),
    .out_comb (oc8)
`ifdef MUX32_SEL_PARITY_EN
    ,
    .out_par  (par8)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    en      = 1'b1;
    in1     = 32'hFFFF_FFFF;
    sel1    = 5'd5;
    for (int e = 0; e < 2; e++) begin
      tick();
      n_checks++;
      if (out1 !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_out edge%0d: got %b want 0", e, out1);
      end
      n_checks++;
      if (out8 !== 8'h00) begin
        n_fail++;
        $display("FAIL reset_out8 edge%0d: got %h want 00", e, out8);
      end
    end
    n_checks++;
    if (oc1 !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_comb: got %b want 1", oc1);
    end
    reset_n = 1'b1;
    tick();
    n_checks++;
    if (out1 !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release: got %b want 1", out1);
    end
  endtask

  task automatic test_walk();
    logic [31:0] r;
    en = 1'b1;
    for (int i = 0; i < 32; i++) begin
      r    = $urandom;
      r[i] = 1'b0;
      in1  = r;
      sel1 = 5'(i);
      #1;
      n_checks++;
      if (oc1 !== 1'b0) begin
        n_fail++;
        $display("FAIL walk_comb0 sel=%0d: got %b want 0", i, oc1);
      end
      tick();
      n_checks++;
      if (out1 !== 1'b0) begin
        n_fail++;
        $display("FAIL walk_out0 sel=%0d: got %b want 0", i, out1);
      end
      r[i] = 1'b1;
      in1  = r;
      #1;
      n_checks++;
      if (oc1 !== 1'b1) begin
        n_fail++;
        $display("FAIL walk_comb1 sel=%0d: got %b want 1", i, oc1);
      end
      n_checks++;
      if (out1 !== 1'b0) begin
        n_fail++;
        $display("FAIL walk_lat sel=%0d: got %b want 0 before edge", i, out1);
      end
      tick();
      n_checks++;
      if (out1 !== 1'b1) begin
        n_fail++;
        $display("FAIL walk_out1 sel=%0d: got %b want 1", i, out1);
      end
    end
  endtask

  task automatic test_enable_hold();
    en   = 1'b1;
    in1  = 32'h0000_0001;
    sel1 = 5'd0;
    tick();
    n_checks++;
    if (out1 !== 1'b1) begin
      n_fail++;
      $display("FAIL en_load: got %b want 1", out1);
    end
    en  = 1'b0;
    in1 = 32'h0000_0000;
    #1;
    n_checks++;
    if (oc1 !== 1'b0) begin
      n_fail++;
      $display("FAIL en_comb: got %b want 0", oc1);
    end
    for (int e = 0; e < 2; e++) begin
      tick();
      n_checks++;
      if (out1 !== 1'b1) begin
        n_fail++;
        $display("FAIL en_hold edge%0d: got %b want 1", e, out1);
      end
    end
    // reset must clear even while enable is low
    reset_n = 1'b0;
    tick();
    n_checks++;
    if (out1 !== 1'b0) begin
      n_fail++;
      $display("FAIL en_reset: got %b want 0", out1);
    end
    reset_n = 1'b1;
    in1     = 32'h0000_0001;
    tick();
    n_checks++;
    if (out1 !== 1'b0) begin
      n_fail++;
      $display("FAIL en_post_reset_hold: got %b want 0", out1);
    end
    en = 1'b1;
  endtask

  task automatic test_half_boundary();
    logic [4:0] sv [4];
    logic       ev [4];
    sv = '{5'd15, 5'd16, 5'd14, 5'd17};
    ev = '{1'b1, 1'b1, 1'b0, 1'b0};
    en  = 1'b1;
    in1 = 32'h0001_8000;
    for (int k = 0; k < 4; k++) begin
      sel1 = sv[k];
      #1;
      n_checks++;
      if (oc1 !== ev[k]) begin
        n_fail++;
        $display("FAIL half_comb sel=%0d: got %b want %b", sv[k], oc1, ev[k]);
      end
      tick();
      n_checks++;
      if (out1 !== ev[k]) begin
        n_fail++;
        $display("FAIL half_out sel=%0d: got %b want %b", sv[k], out1, ev[k]);
      end
    end
  endtask

  task automatic test_width8();
    en = 1'b1;
    for (int k = 0; k < 32; k++) in8[k*8 +: 8] = 8'(k) + 8'h40;
    sel8 = 5'd31;
    tick();
    n_checks++;
    if (out8 !== 8'h5F) begin
      n_fail++;
      $display("FAIL w8_sel31: got %h want 5f", out8);
    end
    sel8 = 5'd0;
    #1;
    n_checks++;
    if (oc8 !== 8'h40) begin
      n_fail++;
      $display("FAIL w8_comb0: got %h want 40", oc8);
    end
    n_checks++;
    if (out8 !== 8'h5F) begin
      n_fail++;
      $display("FAIL w8_lat: got %h want 5f before edge", out8);
    end
    tick();
    n_checks++;
    if (out8 !== 8'h40) begin
      n_fail++;
      $display("FAIL w8_sel0: got %h want 40", out8);
    end
  endtask

  task automatic test_back_to_back();
    en = 1'b1;
    // new data and new select land together on one edge
    in8[17*8 +: 8] = 8'hA5;
    sel8 = 5'd17;
    tick();
    n_checks++;
    if (out8 !== 8'hA5) begin
      n_fail++;
      $display("FAIL b2b_first: got %h want a5", out8);
    end
    in8[9*8 +: 8] = 8'h3C;
    sel8 = 5'd9;
    tick();
    n_checks++;
    if (out8 !== 8'h3C) begin
      n_fail++;
      $display("FAIL b2b_second: got %h want 3c", out8);
    end
  endtask

`ifdef MUX32_SEL_PARITY_EN
  task automatic test_parity();
    en = 1'b1;
    in8[3*8 +: 8] = 8'h07;
    sel8 = 5'd3;
    tick();
    n_checks++;
    if (par8 !== 1'b1) begin
      n_fail++;
      $display("FAIL par_07: got %b want 1", par8);
    end
    in8[3*8 +: 8] = 8'h03;
    tick();
    n_checks++;
    if (par8 !== 1'b0) begin
      n_fail++;
      $display("FAIL par_03: got %b want 0", par8);
    end
    in8[3*8 +: 8] = 8'h01;
    tick();
    reset_n = 1'b0;
    tick();
    n_checks++;
    if (par8 !== 1'b0) begin
      n_fail++;
      $display("FAIL par_reset: got %b want 0", par8);
    end
    reset_n = 1'b1;
  endtask
`endif

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset_n  = 1'b0;
    en       = 1'b0;
    in1      = '0;
    sel1     = '0;
    in8      = '0;
    sel8     = '0;
    #1;
    test_reset();
    test_walk();
    test_enable_hold();
    test_half_boundary();
    test_width8();
    test_back_to_back();
`ifdef MUX32_SEL_PARITY_EN
    test_parity();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mux32_sel_reg.md
Name: mux32_sel_reg

Overview:
- Registered 32-to-1 selector; picks one of 32 input lanes by a 5-bit select and presents it on a registered output.
- Built as a two-level tree: two 16:1 stages on sel[3:0], then a final 2:1 stage on sel[4].
- Used as the generic bit/lane selector in the pipelined CPU datapath, e.g. register-file read ports and forwarding selects.

Parameters:
- WIDTH, 1, bits per input lane and width of the output (legal range 1..64).

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  synchronous active-low reset.
- en  input  1  capture enable; output register loads only when en=1.
- in  input  32*WIDTH  lane k occupies in[k*WIDTH +: WIDTH], k=0..31.
- sel  input  5  lane index 0..31.
- out  output  WIDTH  registered selected lane.
- out_comb  output  WIDTH  combinational selected lane (same cycle, unregistered).

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-low (reset_n). Sampled only on the rising edge of clk.
- Combinational path: out_comb = lane[sel] at all times.
  - sel[3:0] picks within the lower half (lanes 0..15) and the upper half (lanes 16..31).
  - sel[4]=0 chooses the lower half; sel[4]=1 chooses the upper half.
  - No X-propagation tricks: every sel value 0..31 is legal and fully decoded. There are no out-of-range codes.
- Registered path, evaluated at each rising clk edge:
  - reset_n=0: out <= 0 (all WIDTH bits), regardless of en.
  - reset_n=1, en=1: out <= out_comb.
  - reset_n=1, en=0: out holds its value.
- Latency:
  - out: 1 cycle from an in/sel change to out.
  - out_comb: 0 cycles.
- Reset mid-operation: the clearing takes effect on the edge where reset_n is sampled low. The first load after release occurs on the first edge with reset_n=1 and en=1.
- Simultaneous in and sel change: out reflects the new sel applied to the new in, sampled at the edge.
- Reset state of outputs:
  - out = 0.
  - out_comb is purely combinational and not affected by reset.

Optional Feature:
- Macro: MUX32_SEL_PARITY_EN.
- Defined:
  - Adds output port out_par (1 bit) = XOR-reduction of the registered out.
  - out_par is updated on the same edge as out and resets to 0.
- Undefined: the port out_par does not exist; all other behaviour is identical.

Decomposition:
- Shared package mux_pkg holds:
  - constants NUM_LANES=32 and SEL_W=5;
  - typedef sel_t (logic [SEL_W-1:0]).
- Sub-modules:
  - mux16_sel: parameterized WIDTH, 16:1, 4-bit select, combinational. Instantiated twice, for the lower and upper halves.
  - mux2_sel: WIDTH, 2:1, combinational. Instantiated once for the final stage.
- The top module adds the output register, the enable, and the optional parity.

Test Plan:
- Walking-ones sweep, WIDTH=1, en=1, after reset. For sel=i (i=0..31): set in[i]=0 then in[i]=1, other bits random. out_comb follows in[i] immediately; out follows in[i] one edge later.
- Reset: hold reset_n=0 for 2 edges with in=32'hFFFF_FFFF, sel=5. out=0. Release; after 1 edge, out=1.
- Enable hold: with in=32'h0000_0001, sel=0, en=1, out=1 after one edge. Then en=0 and in=0: out stays 1 and out_comb=0.
- Half boundary: in=32'h0001_8000. sel=15 -> 1; sel=16 -> 1; sel=14 -> 0; sel=17 -> 0. Confirms sel[4] half selection.
- WIDTH=8: lane k holds value k+8'h40. sel=31 -> out=8'h5F; sel=0 -> 8'h40, both one cycle after the select is applied.
- Parity (macro defined, WIDTH=8): selected lane 8'h07 -> out_par=1; selected lane 8'h03 -> out_par=0. out_par=0 during reset.
